// File: rtl/vcm_sweep_ctrl.sv
// vcm_sweep_ctrl: VCM focus-sweep sequencer (REQ/ACK code writes, settle timer, abort).
// Define VCM_PEAK_TRACK_EN to add the MEASURE state and BEST_POS peak tracking.
module vcm_sweep_ctrl #(
   parameter int DATA_W   = 10,
   parameter int STEP_W   = 10,
   parameter int SETTLE_W = 20,
   parameter int FOCUS_W  = 16
) (
   input  logic                CLK_50,
   input  logic                RESET,
   input  logic                START,
   input  logic                ABORT,
   input  logic [1:0]          MODE,
   input  logic [DATA_W-1:0]   POS_MIN,
   input  logic [DATA_W-1:0]   POS_MAX,
   input  logic [DATA_W-1:0]   STEP_SIZE,
   input  logic [SETTLE_W-1:0] SETTLE,
   output logic                VCM_REQ,
   output logic [15:0]         VCM_DATA,
   input  logic                VCM_ACK,
   input  logic [FOCUS_W-1:0]  FOCUS_VAL,
   input  logic                FOCUS_VLD,
   output logic [STEP_W-1:0]   STEP,
   output logic                BUSY,
   output logic                DONE,
   output logic [DATA_W-1:0]   BEST_POS
);

   // state      | meaning
   // ST_IDLE    | waiting for START, config not latched
   // ST_REQ     | VCM_REQ high, waiting for VCM_ACK
   // ST_SETTLE  | settle down-counter running after an ACK
   // ST_MEASURE | waiting for FOCUS_VLD (peak tracking builds only)
   // ST_NEXT    | one cycle: compute next code / direction / finish
   // ST_DONE    | one-cycle DONE pulse
   typedef enum logic [2:0] {
      ST_IDLE, ST_REQ, ST_SETTLE, ST_MEASURE, ST_NEXT, ST_DONE
   } state_t;

   state_t state, state_nxt;

   logic [1:0]          mode_q;
   logic [DATA_W-1:0]   min_q, max_q, step_q;
   logic [SETTLE_W-1:0] settle_q, settle_cnt;
   logic [DATA_W-1:0]   pos, pos_nxt;
   logic                dir_up, dir_nxt;
   logic                abort_pend;
   logic [STEP_W-1:0]   step_cnt;

   logic [DATA_W:0]     up_sum, dn_diff;
   logic [DATA_W-1:0]   up_pos, dn_pos;
   logic                up_end, dn_end, degen;

   // One extra bit so the sum cannot wrap and the difference flags underflow.
   always_comb begin
      up_sum  = {1'b0, pos} + {1'b0, step_q};
      dn_diff = {1'b0, pos} - {1'b0, step_q};
      up_pos  = (up_sum > {1'b0, max_q}) ? max_q : up_sum[DATA_W-1:0];
      dn_pos  = (dn_diff[DATA_W] || (dn_diff[DATA_W-1:0] < min_q)) ? min_q
                                                                   : dn_diff[DATA_W-1:0];
   end

   assign up_end = (pos >= max_q);
   assign dn_end = (pos <= min_q);
   assign degen  = (max_q <= min_q);

   always_comb begin
      state_nxt = state;
      pos_nxt   = pos;
      dir_nxt   = dir_up;
      case (state)
         ST_IDLE: begin
            if (START) state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (VCM_ACK) state_nxt = (abort_pend || ABORT) ? ST_DONE : ST_SETTLE;
         end
         ST_SETTLE: begin
            if (ABORT) begin
               state_nxt = ST_DONE;
            end else if (settle_cnt == '0) begin
`ifdef VCM_PEAK_TRACK_EN
               state_nxt = ST_MEASURE;
`else
               state_nxt = ST_NEXT;
`endif
            end
         end
         ST_MEASURE: begin
`ifdef VCM_PEAK_TRACK_EN
            if (ABORT)          state_nxt = ST_DONE;
            else if (FOCUS_VLD) state_nxt = ST_NEXT;
`else
            state_nxt = ST_NEXT;
`endif
         end
         ST_NEXT: begin
            if (ABORT || degen || (mode_q == 2'd2)) begin
               state_nxt = ST_DONE;
            end else if (dir_up) begin
               if (!up_end) begin
                  pos_nxt   = up_pos;
                  state_nxt = ST_REQ;
               end else if (mode_q == 2'd0) begin
                  state_nxt = ST_DONE;
               end else begin
                  // Reverse and step at once so the end code is not written twice.
                  dir_nxt   = 1'b0;
                  pos_nxt   = dn_pos;
                  state_nxt = ST_REQ;
               end
            end else begin
               if (!dn_end) begin
                  pos_nxt   = dn_pos;
                  state_nxt = ST_REQ;
               end else if (mode_q == 2'd3) begin
                  dir_nxt   = 1'b1;
                  pos_nxt   = up_pos;
                  state_nxt = ST_REQ;
               end else begin
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         state      <= ST_IDLE;
         mode_q     <= '0;
         min_q      <= '0;
         max_q      <= '0;
         step_q     <= '0;
         settle_q   <= '0;
         settle_cnt <= '0;
         pos        <= '0;
         dir_up     <= 1'b1;
         abort_pend <= 1'b0;
         step_cnt   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (START) begin
                  mode_q     <= MODE;
                  min_q      <= POS_MIN;
                  max_q      <= POS_MAX;
                  step_q     <= (STEP_SIZE == '0) ? DATA_W'(1) : STEP_SIZE;
                  settle_q   <= SETTLE;
                  pos        <= POS_MIN;
                  dir_up     <= 1'b1;
                  abort_pend <= 1'b0;
                  step_cnt   <= '0;
               end
            end
            ST_REQ: begin
               // Abort is held until the in-flight write is acknowledged.
               if (ABORT) abort_pend <= 1'b1;
               if (VCM_ACK) begin
                  if (step_cnt != '1) step_cnt <= step_cnt + STEP_W'(1);
                  settle_cnt <= settle_q;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt != '0) settle_cnt <= settle_cnt - SETTLE_W'(1);
            end
            ST_NEXT: begin
               pos    <= pos_nxt;
               dir_up <= dir_nxt;
            end
            default: begin
            end
         endcase
      end
   end

   assign VCM_REQ  = (state == ST_REQ);
   assign BUSY     = (state != ST_IDLE);
   assign DONE     = (state == ST_DONE);
   assign STEP     = step_cnt;
   assign VCM_DATA = {2'b00, pos, {(14-DATA_W){1'b0}}};

`ifdef VCM_PEAK_TRACK_EN
   logic [FOCUS_W-1:0] best_val;
   logic [DATA_W-1:0]  best_pos;

   // Strict compare: a tie keeps the earlier code.
   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         best_val <= '0;
         best_pos <= '0;
      end else if ((state == ST_IDLE) && START) begin
         best_val <= '0;
         best_pos <= POS_MIN;
      end else if ((state == ST_MEASURE) && FOCUS_VLD && (FOCUS_VAL > best_val)) begin
         best_val <= FOCUS_VAL;
         best_pos <= pos;
      end
   end

   assign BEST_POS = best_pos;
`else
   logic unused_focus;
   assign unused_focus = &{1'b0, FOCUS_VAL, FOCUS_VLD};
   assign BEST_POS     = '0;
`endif

endmodule

// File: doc/vcm_sweep_ctrl.md
Name: vcm_sweep_ctrl

Overview:
- Parametrised VCM focus-sweep sequencer.
- Steps the lens code from POS_MIN to POS_MAX in STEP_SIZE increments.
- Per step: hands one 16-bit VCM word to the I2C writer over a REQ/ACK handshake, waits a programmable settle time, then optionally samples a focus metric and records the peak position.
- Sits between the reset/ready logic and the VCM I2C writer. Adds modes, range limits, settle timing and abort that a fixed stepper lacks.

Parameters:
DATA_W, 10, VCM code width in bits; legal range 1..12
STEP_W, 10, width of the step counter
SETTLE_W, 20, width of the settle counter and SETTLE port
FOCUS_W, 16, width of the focus metric

Ports:
CLK_50  in  1  system clock
RESET  in  1  synchronous, active-high reset
START  in  1  start pulse; sampled only in IDLE
ABORT  in  1  request early termination
MODE  in  2  0 = single ramp up, 1 = up then down, 2 = single position, 3 = continuous triangle
POS_MIN  in  DATA_W  start/low code
POS_MAX  in  DATA_W  end/high code
STEP_SIZE  in  DATA_W  code increment; 0 is treated as 1
SETTLE  in  SETTLE_W  settle cycles after each ACK
VCM_REQ  out  1  write request to the I2C writer
VCM_DATA  out  16  {2'b00, code, (14-DATA_W) zeros}
VCM_ACK  in  1  1-cycle pulse from the writer when the transaction completes
FOCUS_VAL  in  FOCUS_W  focus metric
FOCUS_VLD  in  1  FOCUS_VAL valid strobe
STEP  out  STEP_W  number of completed writes; saturates at all-ones
BUSY  out  1  sweep in progress
DONE  out  1  1-cycle completion pulse
BEST_POS  out  DATA_W  code giving the highest focus value

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal position and best value 0.
- FSM states: IDLE, REQ, SETTLE, MEASURE, NEXT, DONE.
- IDLE:
  - START=1 in cycle n latches MODE, POS_MIN, POS_MAX, STEP_SIZE, SETTLE.
  - Sets pos=POS_MIN, STEP=0, best value=0, BEST_POS=POS_MIN, direction=up.
  - Enters REQ. VCM_REQ and BUSY go high in cycle n+1.
  - Config inputs are ignored after the latch.
- REQ:
  - VCM_REQ held high and VCM_DATA held stable until VCM_ACK.
  - ACK in cycle k: VCM_REQ low in k+1; STEP increments (saturating); SETTLE state is entered.
  - ACK outside REQ is ignored.
- SETTLE:
  - Counts the latched SETTLE cycles, then moves to MEASURE.
  - SETTLE=0 moves on in the next cycle.
- MEASURE: waits for FOCUS_VLD, then goes to NEXT. Without the feature macro this state is bypassed (SETTLE goes directly to NEXT).
- NEXT (one cycle):
  - Up: nxt = pos + STEP_SIZE, computed in DATA_W+1 bits. If nxt > POS_MAX, clamp to POS_MAX. If pos already equals POS_MAX, the leg is finished.
  - Down: mirror of up. Clamp to POS_MIN; no underflow wrap.
  - Leg finished:
    - mode 0: go to DONE.
    - mode 1: first end switches to down; POS_MIN end goes to DONE.
    - mode 3: reverse direction indefinitely.
    - mode 2: always goes to DONE after the first write.
  - Otherwise go to REQ with the new pos.
- Degenerate range: POS_MAX <= POS_MIN gives exactly one write at POS_MIN, then DONE, in every mode including 3.
- DONE: DONE=1 for one cycle, BUSY still 1 in that cycle; IDLE next, with BUSY=0.
- ABORT:
  - Sampled in every non-IDLE state.
  - In REQ, it is deferred until VCM_ACK so no I2C transaction is cut off; on that ACK the FSM goes to DONE.
  - In other states it goes to DONE on the next cycle.
  - STEP and BEST_POS are retained.
- START while BUSY is ignored. START and ABORT together in IDLE: START wins, ABORT is ignored.
- RESET mid-sweep: returns to IDLE next edge with all outputs 0. The I2C writer is responsible for its own cleanup.
- STEP and BEST_POS hold their values in IDLE until the next START.

Optional Feature:
- Macro: VCM_PEAK_TRACK_EN.
- Defined:
  - MEASURE state present.
  - On FOCUS_VLD, if FOCUS_VAL > best value (strict), update best value and set BEST_POS=pos in the same edge.
  - Ties keep the earlier position.
  - FOCUS_VLD outside MEASURE is ignored.
- Undefined:
  - No MEASURE state; FOCUS_VAL and FOCUS_VLD are unused.
  - BEST_POS is constant 0.

Test Plan:
- Mode 0, MIN=0, MAX=10, STEP_SIZE=3, SETTLE=4, ACK 5 cycles after each REQ -> codes 0,3,6,9,10; STEP=5; one DONE pulse; VCM_DATA for code 9 = 16'h0090 (DATA_W=10).
- Mode 1, MIN=100, MAX=104, STEP_SIZE=2 -> codes 100,102,104,102,100; DONE after the 5th ACK; direction clamps correct at both ends.
- Mode 2, and separately MAX=5 with MIN=5 in mode 3 -> exactly one write of the MIN code, then DONE.
- STEP_SIZE=0, SETTLE=0, MIN=0, MAX=2 -> codes 0,1,2; NEXT follows SETTLE in the next cycle.
- ABORT asserted mid-REQ in mode 3 -> VCM_REQ stays high until ACK, then DONE next; START pulsed while BUSY has no effect; STEP shows writes completed.
- With VCM_PEAK_TRACK_EN, focus values 10,40,40,25 on codes 0,4,8,12 -> BEST_POS=4 (tie keeps first). RESET mid-SETTLE -> all outputs 0 next cycle.
